slb: RTL and testbench
======================

# slb

Store/load buffer of the out-of-order RISC-V core, 16-entry in-order circular queue between dispatch and the memory controller. Accepts memory ops from dispatch, captures operands from the result broadcasts, and issues to memory strictly in program order. Returns load data to the ROB. Performs each store only after the ROB's `oSLB_commit_en` names its nick.

## Interface
- `DEPTH`, 16: entries; power of two.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; when low, no state changes and outputs hold.
- `clr` in 1: ROB mispredict flush.
- `oINF_full` out 1: dispatch back-pressure.
- `iDP_en` in 1: dispatch valid.
- `iDP_op` in `OpBus`: one of LB/LH/LW/LBU/LHU/SB/SH/SW.
- `iDP_nick` in `NickBus`(5): ROB tag.
- `iDP_imm` in 32: offset.
- `iDP_rs1_nick` / `iDP_rs2_nick` in 5 each: producer tag; 0 = value valid.
- `iDP_rs1_dt` / `iDP_rs2_dt` in 32 each: operand values.
- `iEX_en` in 1, `iEX_nick` in 5, `iEX_dt` in 32: ALU broadcast.
- `iROB_commit_en` in 1, `iROB_commit_nick` in 5: store commit from ROB.
- `oMC_en` out 1: memory request.
- `oMC_wr` out 1: 1 = store.
- `oMC_addr` out 32: byte address.
- `oMC_len` out 2: bytes−1.
- `oMC_dt` out 32: store data.
- `iMC_done` in 1: request complete.
- `iMC_dt` in 32: raw load data, LSB-aligned.
- `oROB_en` out 1, `oROB_nick` out 5, `oROB_dt` out 32: load result, also snooped internally as a broadcast.

## Operation
- Entry fields:
  - busy, op, nick, imm;
  - rs1/rs2 value+tag;
  - committed bit (stores).
- Pointers `head`/`tail` are `log2(DEPTH)` bits and wrap naturally. `count` is `log2(DEPTH)+1` bits.
- Dispatch writes at `tail` when `iDP_en`.
- `oINF_full = (count >= DEPTH-1)`. This one-slot margin covers one cycle of dispatch latency. Dispatch while `count==DEPTH` is ignored.
- Snoop: every busy entry whose tag equals a broadcasting nick (`iEX` or this block's `oROB`) takes the data and clears the tag.
  - Same-cycle dispatch whose source tag matches a live broadcast stores the broadcast value with tag 0.
- Commit: the entry whose nick equals `iROB_commit_nick` sets committed. Committed stores are always a contiguous run from `head`; `ccount` tracks it.
- Issue FSM:
  - IDLE → REQ when the head entry is busy, rs1 tag==0, and either it is a load, or it is a store with rs2 tag==0 and committed.
  - REQ drives `oMC_*` and holds them until `iMC_done`.
  - REQ → IDLE on `iMC_done`: head entry freed, `head+1`, `count-1`.
  - A load additionally pulses `oROB_en` for one cycle with the extended data.
- Address: `rs1+imm`, mod 2^32.
- Length: B→0, H→1, W→3.
- Load extension:
  - LB/LH sign-extend bit 7/15;
  - LBU/LHU zero-extend;
  - LW passes through.
- Store data: `rs2` unmodified; the memory controller uses the low `len+1` bytes.
- Flush (`clr`):
  - All uncommitted entries are dropped; `tail = head + ccount`, `count = ccount`.
  - An in-flight load is allowed to finish on the bus but its `oROB_en` is suppressed. The FSM then returns to IDLE without popping; the head entry has already been dropped.
  - An in-flight committed store completes normally.
- Simultaneous events:
  - dispatch + pop: `count` unchanged.
  - commit + flush: commit applied first.
  - done + flush: pop applies only to committed stores.
- Nick 0 never denotes a real instruction.

## Timing
- Reset, async on `rst` low, applies to all of:
  - `head`, `tail`, `count`, `ccount` = 0;
  - FSM IDLE;
  - all `oMC_*` = 0;
  - `oROB_en` = 0, `oROB_nick` = 0, `oROB_dt` = 0;
  - `oINF_full` = 0;
  - all busy/committed bits = 0.
- Reset mid-request drops the transaction; the memory controller resets in the same domain.
- Head ready in cycle t → `oMC_en` high from t+1 (registered).
- `iMC_done` in cycle d → `oMC_en` low and `oROB_en` high in d+1 → next head may request in d+2.
- Snooped value is usable for issue the cycle after the broadcast.
- `oROB_en` is a single-cycle pulse.

## Structure
- `config.v` holds:
  - `OpBus` and the LB…SW opcodes;
  - `NickBus`, `DataBus`, `AddrBus`;
  - `SlbNum`;
  - FSM state encodings.
- One sub-module, `slb_ldext`: combinational load extension (op, raw) → data.

## Test plan
- Reset with `rst`=0, then dispatch LW, rs1=0x100 ready, imm=4 → `oMC_en`, `wr`=0, `addr`=0x104, `len`=3; `iMC_done` with 0xDEADBEEF → `oROB_en`, `dt`=0xDEADBEEF.
- LB returning raw 0x80 → 0xFFFFFF80; LBU returning raw 0x80 → 0x00000080; LH returning raw 0x8001 → 0xFFFF8001.
- SW with rs2 ready: no request until commit of its nick; after commit → `wr`=1, `dt`=rs2, no `oROB_en`.
- Load whose rs1 tag=7; `iEX_en` nick 7 with dt=0x200, imm=−4 → `addr`=0x1FC. Also check same-cycle dispatch/broadcast capture.
- Fill 15 entries → `oINF_full`=1; one pop → 0; `head`/`tail` wrap past 15 with order preserved.
- Committed SW, then 3 uncommitted loads (first in flight), `clr` → in-flight load result suppressed, store still performed, `count`=0 at end.

Source files
------------

// File: rtl/slb_pkg.sv
// slb_pkg: opcode, tag and entry types shared by the store/load buffer.
// Stores are the opcodes with bit 3 set; bits 1:0 give the access width.
package slb_pkg;

  localparam int SlbNum = 16;

  typedef logic [3:0]  OpBus;
  typedef logic [4:0]  NickBus;
  typedef logic [31:0] DataBus;
  typedef logic [31:0] AddrBus;

  localparam OpBus OP_LB  = 4'h0;
  localparam OpBus OP_LH  = 4'h1;
  localparam OpBus OP_LW  = 4'h2;
  localparam OpBus OP_LBU = 4'h4;
  localparam OpBus OP_LHU = 4'h5;
  localparam OpBus OP_SB  = 4'h8;
  localparam OpBus OP_SH  = 4'h9;
  localparam OpBus OP_SW  = 4'ha;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  typedef struct packed {
    logic   busy;
    logic   cmt;
    OpBus   op;
    NickBus nick;
    DataBus imm;
    NickBus t1;
    DataBus v1;
    NickBus t2;
    DataBus v2;
  } slb_ent_t;

  function automatic logic is_st(OpBus op);
    return op[3];
  endfunction

  function automatic logic [1:0] len_of(OpBus op);
    return {op[1], op[1] | op[0]};
  endfunction

endpackage

// File: rtl/slb_if.sv
// slb_if: dispatch, broadcast, commit, memory and ROB signals of the
// store/load buffer; slave is the buffer side, master the environment.
interface slb_if;
  import slb_pkg::*;

  logic   oINF_full;
  logic   iDP_en;
  OpBus   iDP_op;
  NickBus iDP_nick;
  DataBus iDP_imm;
  NickBus iDP_rs1_nick;
  NickBus iDP_rs2_nick;
  DataBus iDP_rs1_dt;
  DataBus iDP_rs2_dt;
  logic   iEX_en;
  NickBus iEX_nick;
  DataBus iEX_dt;
  logic   iROB_commit_en;
  NickBus iROB_commit_nick;
  logic   oMC_en;
  logic   oMC_wr;
  AddrBus oMC_addr;
  logic [1:0] oMC_len;
  DataBus oMC_dt;
  logic   iMC_done;
  DataBus iMC_dt;
  logic   oROB_en;
  NickBus oROB_nick;
  DataBus oROB_dt;

  modport slave (
    output oINF_full, oMC_en, oMC_wr, oMC_addr, oMC_len, oMC_dt,
    output oROB_en, oROB_nick, oROB_dt,
    input  iDP_en, iDP_op, iDP_nick, iDP_imm,
    input  iDP_rs1_nick, iDP_rs2_nick, iDP_rs1_dt, iDP_rs2_dt,
    input  iEX_en, iEX_nick, iEX_dt,
    input  iROB_commit_en, iROB_commit_nick,
    input  iMC_done, iMC_dt
  );

  modport master (
    input  oINF_full, oMC_en, oMC_wr, oMC_addr, oMC_len, oMC_dt,
    input  oROB_en, oROB_nick, oROB_dt,
    output iDP_en, iDP_op, iDP_nick, iDP_imm,
    output iDP_rs1_nick, iDP_rs2_nick, iDP_rs1_dt, iDP_rs2_dt,
    output iEX_en, iEX_nick, iEX_dt,
    output iROB_commit_en, iROB_commit_nick,
    output iMC_done, iMC_dt
  );

endinterface

// File: rtl/slb_ldext.sv
// slb_ldext: sign/zero extension of LSB-aligned raw load data.
// Stores and LW pass the raw word through.
module slb_ldext
  import slb_pkg::*;
(
  input  OpBus   op_i,
  input  DataBus raw_i,
  output DataBus dt_o
);

  always_comb begin
    dt_o = raw_i;
    unique case (1'b1)
      (op_i == OP_LB):  dt_o = {{24{raw_i[7]}}, raw_i[7:0]};
      (op_i == OP_LH):  dt_o = {{16{raw_i[15]}}, raw_i[15:0]};
      (op_i == OP_LBU): dt_o = {24'h0, raw_i[7:0]};
      (op_i == OP_LHU): dt_o = {16'h0, raw_i[15:0]};
      default:          dt_o = raw_i;
    endcase
  end

endmodule

// File: rtl/slb.sv
// slb: in-order store/load queue between dispatch and the memory controller.
// Captures operands from broadcasts; stores issue only once committed.
module slb
  import slb_pkg::*;
#(
  parameter int DEPTH = SlbNum
) (
  input logic  clk,
  input logic  rst,
  input logic  rdy,
  input logic  clr,
  slb_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  slb_ent_t   ent_q [DEPTH];
  slb_ent_t   ent_d [DEPTH];
  ptr_t       head_q, head_d, tail_q, tail_d;
  cnt_t       count_q, count_d, ccount_q, ccount_d, ccount_n;
  logic [0:0] state_q, state_d;
  logic       kill_q, kill_d;
  logic       mc_en_q, mc_en_d, mc_wr_q, mc_wr_d;
  AddrBus     mc_addr_q, mc_addr_d;
  logic [1:0] mc_len_q, mc_len_d;
  DataBus     mc_dt_q, mc_dt_d;
  logic       rob_en_q, rob_en_d;
  NickBus     rob_nick_q, rob_nick_d;
  DataBus     rob_dt_q, rob_dt_d;

  slb_ent_t hd;
  DataBus   ld_dt;
  logic     hd_ld, hd_rdy, push, pop, pop_st, cmt_hit;

  assign hd    = ent_q[head_q];
  assign hd_ld = !is_st(hd.op);

  slb_ldext u_ldext (
    .op_i  (hd.op),
    .raw_i (bus.iMC_dt),
    .dt_o  (ld_dt)
  );

  function automatic logic hit(NickBus t, logic en, NickBus n);
    return en && (t != '0) && (t == n);
  endfunction

  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    state_d    = state_q;
    kill_d     = kill_q;
    mc_en_d    = mc_en_q;
    mc_wr_d    = mc_wr_q;
    mc_addr_d  = mc_addr_q;
    mc_len_d   = mc_len_q;
    mc_dt_d    = mc_dt_q;
    rob_en_d   = 1'b0;
    rob_nick_d = rob_nick_q;
    rob_dt_d   = rob_dt_q;
    push       = 1'b0;
    pop        = 1'b0;
    pop_st     = 1'b0;
    cmt_hit    = 1'b0;
    hd_rdy     = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy) begin
        if (hit(ent_q[i].t1, bus.iEX_en, bus.iEX_nick)) begin
          ent_d[i].v1 = bus.iEX_dt;
          ent_d[i].t1 = '0;
        end else if (hit(ent_q[i].t1, rob_en_q, rob_nick_q)) begin
          ent_d[i].v1 = rob_dt_q;
          ent_d[i].t1 = '0;
        end
        if (hit(ent_q[i].t2, bus.iEX_en, bus.iEX_nick)) begin
          ent_d[i].v2 = bus.iEX_dt;
          ent_d[i].t2 = '0;
        end else if (hit(ent_q[i].t2, rob_en_q, rob_nick_q)) begin
          ent_d[i].v2 = rob_dt_q;
          ent_d[i].t2 = '0;
        end
        if (bus.iROB_commit_en && is_st(ent_q[i].op) &&
            !ent_q[i].cmt &&
            ent_q[i].nick == bus.iROB_commit_nick) begin
          ent_d[i].cmt = 1'b1;
          cmt_hit      = 1'b1;
        end
      end
    end

    // A flushed load still finishes on the bus but is neither popped nor reported.
    if (state_q == ST_REQ && bus.iMC_done) begin
      state_d   = ST_IDLE;
      kill_d    = 1'b0;
      mc_en_d   = 1'b0;
      mc_wr_d   = 1'b0;
      mc_addr_d = '0;
      mc_len_d  = '0;
      mc_dt_d   = '0;
      if (!kill_q && !(clr && hd_ld)) begin
        pop                  = 1'b1;
        pop_st               = !hd_ld;
        ent_d[head_q].busy   = 1'b0;
        ent_d[head_q].cmt    = 1'b0;
        head_d               = head_q + ptr_t'(1);
        if (hd_ld) begin
          rob_en_d   = 1'b1;
          rob_nick_d = hd.nick;
          rob_dt_d   = ld_dt;
        end
      end
    end else if (state_q == ST_REQ && clr && hd_ld) begin
      kill_d = 1'b1;
    end

    ccount_n = ccount_q + cnt_t'(cmt_hit) - cnt_t'(pop_st);
    ccount_d = ccount_n;

    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!ent_d[i].cmt) ent_d[i].busy = 1'b0;
      end
      count_d = ccount_n;
      tail_d  = head_d + ptr_t'(ccount_n);
    end else begin
      push = bus.iDP_en && (count_q != cnt_t'(DEPTH));
      if (push) begin
        ent_d[tail_q].busy = 1'b1;
        ent_d[tail_q].cmt  = 1'b0;
        ent_d[tail_q].op   = bus.iDP_op;
        ent_d[tail_q].nick = bus.iDP_nick;
        ent_d[tail_q].imm  = bus.iDP_imm;
        ent_d[tail_q].t1   = bus.iDP_rs1_nick;
        ent_d[tail_q].v1   = bus.iDP_rs1_dt;
        ent_d[tail_q].t2   = bus.iDP_rs2_nick;
        ent_d[tail_q].v2   = bus.iDP_rs2_dt;
        if (hit(bus.iDP_rs1_nick, bus.iEX_en, bus.iEX_nick)) begin
          ent_d[tail_q].t1 = '0;
          ent_d[tail_q].v1 = bus.iEX_dt;
        end else if (hit(bus.iDP_rs1_nick, rob_en_q, rob_nick_q)) begin
          ent_d[tail_q].t1 = '0;
          ent_d[tail_q].v1 = rob_dt_q;
        end
        if (hit(bus.iDP_rs2_nick, bus.iEX_en, bus.iEX_nick)) begin
          ent_d[tail_q].t2 = '0;
          ent_d[tail_q].v2 = bus.iEX_dt;
        end else if (hit(bus.iDP_rs2_nick, rob_en_q, rob_nick_q)) begin
          ent_d[tail_q].t2 = '0;
          ent_d[tail_q].v2 = rob_dt_q;
        end
        tail_d = tail_q + ptr_t'(1);
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end

    hd_rdy = hd.busy && (hd.t1 == '0) &&
             (hd_ld || ((hd.t2 == '0) && hd.cmt));
    if (state_q == ST_IDLE && hd_rdy && !(clr && !hd.cmt)) begin
      state_d   = ST_REQ;
      mc_en_d   = 1'b1;
      mc_wr_d   = !hd_ld;
      mc_addr_d = hd.v1 + hd.imm;
      mc_len_d  = len_of(hd.op);
      mc_dt_d   = hd_ld ? '0 : hd.v2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ccount_q   <= '0;
      state_q    <= ST_IDLE;
      kill_q     <= 1'b0;
      mc_en_q    <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_addr_q  <= '0;
      mc_len_q   <= '0;
      mc_dt_q    <= '0;
      rob_en_q   <= 1'b0;
      rob_nick_q <= '0;
      rob_dt_q   <= '0;
    end else if (rdy) begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ccount_q   <= ccount_d;
      state_q    <= state_d;
      kill_q     <= kill_d;
      mc_en_q    <= mc_en_d;
      mc_wr_q    <= mc_wr_d;
      mc_addr_q  <= mc_addr_d;
      mc_len_q   <= mc_len_d;
      mc_dt_q    <= mc_dt_d;
      rob_en_q   <= rob_en_d;
      rob_nick_q <= rob_nick_d;
      rob_dt_q   <= rob_dt_d;
    end
  end

  assign bus.oINF_full = (count_q >= cnt_t'(DEPTH - 1));
  assign bus.oMC_en    = mc_en_q;
  assign bus.oMC_wr    = mc_wr_q;
  assign bus.oMC_addr  = mc_addr_q;
  assign bus.oMC_len   = mc_len_q;
  assign bus.oMC_dt    = mc_dt_q;
  assign bus.oROB_en   = rob_en_q;
  assign bus.oROB_nick = rob_nick_q;
  assign bus.oROB_dt   = rob_dt_q;

endmodule

// File: tb/tb_slb.sv
// tb_slb: randomized bench for slb against an in-order queue model.
// Expected addresses and load data come from arithmetic on the op rules.
module tb_slb;
  import slb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clr = 1'b0;
  int   errors = 0;
  int   checks = 0;

  slb_if bus ();

  slb #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    NickBus      nick;
    OpBus        op;
  } req_t;

  req_t sb[$];

  function automatic logic [31:0] m_ext(OpBus op, logic [31:0] raw);
    logic [31:0] b;
    logic [31:0] h;
    b = raw % 256;
    h = raw % 65536;
    case (op)
      OP_LB:   return (b >= 128) ? b - 256 : b;
      OP_LH:   return (h >= 32768) ? h - 65536 : h;
      OP_LBU:  return b;
      OP_LHU:  return h;
      default: return raw;
    endcase
  endfunction

  function automatic logic [1:0] m_len(OpBus op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default:              return 2'd3;
    endcase
  endfunction

  function automatic OpBus rnd_ld();
    case ($urandom_range(0, 4))
      0:       return OP_LB;
      1:       return OP_LH;
      2:       return OP_LW;
      3:       return OP_LBU;
      default: return OP_LHU;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input OpBus op, input NickBus nick,
                          input logic [31:0] imm,
                          input NickBus t1, input logic [31:0] v1,
                          input NickBus t2, input logic [31:0] v2);
    bus.iDP_en       = 1'b1;
    bus.iDP_op       = op;
    bus.iDP_nick     = nick;
    bus.iDP_imm      = imm;
    bus.iDP_rs1_nick = t1;
    bus.iDP_rs1_dt   = v1;
    bus.iDP_rs2_nick = t2;
    bus.iDP_rs2_dt   = v2;
    tick();
    bus.iDP_en       = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      if (bus.oMC_en) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic mc_done(input logic [31:0] raw);
    bus.iMC_done = 1'b1;
    bus.iMC_dt   = raw;
    tick();
    bus.iMC_done = 1'b0;
  endtask

  task automatic commit(input NickBus n);
    bus.iROB_commit_en   = 1'b1;
    bus.iROB_commit_nick = n;
    tick();
    bus.iROB_commit_en   = 1'b0;
  endtask

  task automatic quiet(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.oMC_en) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL %s stray request got=%0b exp=0", name, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.oMC_en, bus.oMC_wr, bus.oROB_en, bus.oINF_full} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.oMC_en, bus.oMC_wr, bus.oROB_en, bus.oINF_full});
    end
    checks++;
    if ({bus.oMC_addr, bus.oMC_dt, bus.oMC_len} !== '0) begin
      errors++;
      $display("FAIL reset_mc got=%h/%h/%h exp=0",
               bus.oMC_addr, bus.oMC_dt, bus.oMC_len);
    end
    checks++;
    if ({bus.oROB_nick, bus.oROB_dt} !== '0) begin
      errors++;
      $display("FAIL reset_rob got=%h/%h exp=0", bus.oROB_nick, bus.oROB_dt);
    end
    rst = 1'b1;
    tick();
    quiet("reset_idle");
  endtask

  task automatic test_lw();
    dispatch(OP_LW, 5'd1, 32'd4, 5'd0, 32'h100, 5'd0, 32'h0);
    checks++;
    if (bus.oMC_en !== 1'b0) begin
      errors++;
      $display("FAIL lw_early got=%b exp=0", bus.oMC_en);
    end
    tick();
    checks++;
    if ({bus.oMC_en, bus.oMC_wr, bus.oMC_addr, bus.oMC_len} !==
        {1'b1, 1'b0, 32'h104, 2'd3}) begin
      errors++;
      $display("FAIL lw_req got=%b/%b/%h/%0d exp=1/0/104/3",
               bus.oMC_en, bus.oMC_wr, bus.oMC_addr, bus.oMC_len);
    end
    mc_done(32'hDEADBEEF);
    checks++;
    if ({bus.oROB_en, bus.oROB_nick, bus.oROB_dt, bus.oMC_en} !==
        {1'b1, 5'd1, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL lw_rob got=%b/%0d/%h/%b exp=1/1/deadbeef/0",
               bus.oROB_en, bus.oROB_nick, bus.oROB_dt, bus.oMC_en);
    end
    tick();
    checks++;
    if (bus.oROB_en !== 1'b0) begin
      errors++;
      $display("FAIL lw_pulse got=%b exp=0", bus.oROB_en);
    end
  endtask

  task automatic test_ext();
    OpBus        op;
    logic [31:0] raw, v1, imm, ea;
    bit          ok;
    for (int k = 0; k < 9; k++) begin
      case (k)
        0:       begin op = OP_LB;  raw = 32'h80; end
        1:       begin op = OP_LBU; raw = 32'h80; end
        2:       begin op = OP_LH;  raw = 32'h8001; end
        default: begin op = rnd_ld(); raw = $urandom; end
      endcase
      v1  = $urandom;
      imm = $urandom;
      ea  = v1 + imm;
      dispatch(op, NickBus'(k + 2), imm, 5'd0, v1, 5'd0, 32'h0);
      wait_req(ok);
      checks++;
      if (!ok || bus.oMC_addr !== ea || bus.oMC_len !== m_len(op)) begin
        errors++;
        $display("FAIL ext_req%0d got=%b/%h/%0d exp=1/%h/%0d",
                 k, ok, bus.oMC_addr, bus.oMC_len, ea, m_len(op));
      end
      mc_done(raw);
      checks++;
      if (bus.oROB_en !== 1'b1 || bus.oROB_dt !== m_ext(op, raw)) begin
        errors++;
        $display("FAIL ext_dt%0d got=%b/%h exp=1/%h",
                 k, bus.oROB_en, bus.oROB_dt, m_ext(op, raw));
      end
    end
  endtask

  task automatic test_store();
    logic [31:0] v1, v2;
    bit          ok;
    v1 = $urandom;
    v2 = $urandom;
    dispatch(OP_SW, 5'd3, 32'd8, 5'd0, v1, 5'd0, v2);
    quiet("st_uncommitted");
    commit(5'd3);
    wait_req(ok);
    checks++;
    if (!ok || {bus.oMC_wr, bus.oMC_addr, bus.oMC_dt, bus.oMC_len} !==
        {1'b1, v1 + 32'd8, v2, 2'd3}) begin
      errors++;
      $display("FAIL st_req got=%b/%b/%h/%h/%0d exp=1/1/%h/%h/3",
               ok, bus.oMC_wr, bus.oMC_addr, bus.oMC_dt, bus.oMC_len,
               v1 + 32'd8, v2);
    end
    mc_done($urandom);
    checks++;
    if (bus.oROB_en !== 1'b0 || bus.oMC_en !== 1'b0) begin
      errors++;
      $display("FAIL st_done got=%b/%b exp=0/0", bus.oROB_en, bus.oMC_en);
    end
  endtask

  task automatic test_snoop();
    logic [31:0] v, imm;
    bit          ok;
    dispatch(OP_LW, 5'd11, 32'hFFFFFFFC, 5'd7, 32'hDEAD, 5'd0, 32'h0);
    quiet("snoop_wait");
    bus.iEX_en   = 1'b1;
    bus.iEX_nick = 5'd7;
    bus.iEX_dt   = 32'h200;
    tick();
    bus.iEX_en   = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || bus.oMC_addr !== 32'h1FC) begin
      errors++;
      $display("FAIL snoop_addr got=%b/%h exp=1/1fc", ok, bus.oMC_addr);
    end
    mc_done($urandom);
    v   = $urandom;
    imm = $urandom_range(0, 255);
    bus.iEX_en   = 1'b1;
    bus.iEX_nick = 5'd12;
    bus.iEX_dt   = v;
    dispatch(OP_LW, 5'd13, imm, 5'd12, 32'h0BAD, 5'd0, 32'h0);
    bus.iEX_en   = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || bus.oMC_addr !== v + imm) begin
      errors++;
      $display("FAIL snoop_same got=%b/%h exp=1/%h", ok, bus.oMC_addr, v + imm);
    end
    mc_done($urandom);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, r;
    bit          ok;
    a = $urandom;
    b = $urandom;
    r = $urandom;
    dispatch(OP_LW, 5'd14, 32'd0, 5'd0, a, 5'd0, 32'h0);
    dispatch(OP_LW, 5'd15, 32'd0, 5'd0, b, 5'd0, 32'h0);
    wait_req(ok);
    checks++;
    if (!ok || bus.oMC_addr !== a) begin
      errors++;
      $display("FAIL b2b_first got=%b/%h exp=1/%h", ok, bus.oMC_addr, a);
    end
    mc_done(r);
    checks++;
    if ({bus.oMC_en, bus.oROB_en} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap got=%b exp=01", {bus.oMC_en, bus.oROB_en});
    end
    tick();
    checks++;
    if ({bus.oMC_en, bus.oROB_en, bus.oMC_addr} !== {2'b10, b}) begin
      errors++;
      $display("FAIL b2b_second got=%b/%h exp=10/%h",
               {bus.oMC_en, bus.oROB_en}, bus.oMC_addr, b);
    end
    mc_done(r);
    checks++;
    if (bus.oROB_nick !== 5'd15) begin
      errors++;
      $display("FAIL b2b_nick got=%0d exp=15", bus.oROB_nick);
    end
  endtask

  task automatic test_full();
    logic [31:0] base, imm, v, raw;
    OpBus        op;
    req_t        r;
    bit          ok;
    base = $urandom;
    sb.delete();
    for (int k = 0; k < 16; k++) begin
      op  = rnd_ld();
      imm = $urandom;
      dispatch(op, NickBus'(k + 1), imm, 5'd31, 32'h0, 5'd0, 32'h0);
      sb.push_back('{addr: base + imm, nick: NickBus'(k + 1), op: op});
      if (k == 13 || k == 14) begin
        checks++;
        if (bus.oINF_full !== (k == 14)) begin
          errors++;
          $display("FAIL full_at%0d got=%b exp=%b", k + 1, bus.oINF_full, k == 14);
        end
      end
    end
    dispatch(OP_LW, 5'd17, 32'h0, 5'd31, 32'h0, 5'd0, 32'h0);
    bus.iEX_en   = 1'b1;
    bus.iEX_nick = 5'd31;
    bus.iEX_dt   = base;
    tick();
    bus.iEX_en   = 1'b0;
    for (int i = 0; i < 21; i++) begin
      r = sb.pop_front();
      wait_req(ok);
      checks++;
      if (!ok || bus.oMC_addr !== r.addr || bus.oMC_wr !== 1'b0) begin
        errors++;
        $display("FAIL full_req%0d got=%b/%h exp=1/%h", i, ok, bus.oMC_addr, r.addr);
      end
      raw = $urandom;
      mc_done(raw);
      checks++;
      if (bus.oROB_en !== 1'b1 || bus.oROB_nick !== r.nick ||
          bus.oROB_dt !== m_ext(r.op, raw)) begin
        errors++;
        $display("FAIL full_rob%0d got=%b/%0d/%h exp=1/%0d/%h", i,
                 bus.oROB_en, bus.oROB_nick, bus.oROB_dt, r.nick, m_ext(r.op, raw));
      end
      if (i < 2) begin
        checks++;
        if (bus.oINF_full !== (i == 0)) begin
          errors++;
          $display("FAIL full_pop%0d got=%b exp=%b", i, bus.oINF_full, i == 0);
        end
      end
      if (i >= 2 && i < 7) begin
        op = rnd_ld();
        v  = $urandom;
        dispatch(op, NickBus'(i + 16), 32'h0, 5'd0, v, 5'd0, 32'h0);
        sb.push_back('{addr: v, nick: NickBus'(i + 16), op: op});
      end
    end
    quiet("full_drain");
  endtask

  task automatic test_flush_load();
    logic [31:0] a, n;
    bit          ok;
    a = $urandom;
    dispatch(OP_LW, 5'd23, 32'h0, 5'd0, a, 5'd0, 32'h0);
    dispatch(OP_LH, 5'd24, 32'h0, 5'd0, $urandom, 5'd0, 32'h0);
    dispatch(OP_LB, 5'd25, 32'h0, 5'd0, $urandom, 5'd0, 32'h0);
    wait_req(ok);
    checks++;
    if (!ok || bus.oMC_addr !== a) begin
      errors++;
      $display("FAIL fl_req got=%b/%h exp=1/%h", ok, bus.oMC_addr, a);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mc_done($urandom);
    checks++;
    if (bus.oROB_en !== 1'b0) begin
      errors++;
      $display("FAIL fl_suppress got=%b exp=0", bus.oROB_en);
    end
    quiet("fl_dropped");
    n = $urandom;
    dispatch(OP_LW, 5'd26, 32'h0, 5'd0, n, 5'd0, 32'h0);
    wait_req(ok);
    checks++;
    if (!ok || bus.oMC_addr !== n) begin
      errors++;
      $display("FAIL fl_next got=%b/%h exp=1/%h", ok, bus.oMC_addr, n);
    end
    mc_done($urandom);
    checks++;
    if (bus.oROB_en !== 1'b1 || bus.oROB_nick !== 5'd26) begin
      errors++;
      $display("FAIL fl_next_rob got=%b/%0d exp=1/26", bus.oROB_en, bus.oROB_nick);
    end
  endtask

  task automatic test_flush_store();
    logic [31:0] a, d, n;
    bit          ok;
    a = $urandom;
    d = $urandom;
    dispatch(OP_SH, 5'd27, 32'h0, 5'd0, a, 5'd0, d);
    commit(5'd27);
    dispatch(OP_LW, 5'd28, 32'h0, 5'd0, $urandom, 5'd0, 32'h0);
    dispatch(OP_LW, 5'd29, 32'h0, 5'd0, $urandom, 5'd0, 32'h0);
    wait_req(ok);
    checks++;
    if (!ok || {bus.oMC_wr, bus.oMC_addr, bus.oMC_dt, bus.oMC_len} !==
        {1'b1, a, d, 2'd1}) begin
      errors++;
      $display("FAIL fs_req got=%b/%b/%h/%h/%0d exp=1/1/%h/%h/1", ok,
               bus.oMC_wr, bus.oMC_addr, bus.oMC_dt, bus.oMC_len, a, d);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (bus.oMC_en !== 1'b1) begin
      errors++;
      $display("FAIL fs_hold got=%b exp=1", bus.oMC_en);
    end
    mc_done($urandom);
    checks++;
    if ({bus.oROB_en, bus.oINF_full} !== 2'b00) begin
      errors++;
      $display("FAIL fs_done got=%b exp=00", {bus.oROB_en, bus.oINF_full});
    end
    quiet("fs_dropped");
    n = $urandom;
    dispatch(OP_LBU, 5'd30, 32'h0, 5'd0, n, 5'd0, 32'h0);
    wait_req(ok);
    checks++;
    if (!ok || bus.oMC_addr !== n || bus.oMC_len !== 2'd0) begin
      errors++;
      $display("FAIL fs_next got=%b/%h/%0d exp=1/%h/0",
               ok, bus.oMC_addr, bus.oMC_len, n);
    end
    mc_done(32'hFFFF_FF90);
    checks++;
    if (bus.oROB_dt !== 32'h90) begin
      errors++;
      $display("FAIL fs_next_dt got=%h exp=90", bus.oROB_dt);
    end
  endtask

  initial begin
    bus.iDP_en           = 1'b0;
    bus.iDP_op           = OP_LW;
    bus.iDP_nick         = '0;
    bus.iDP_imm          = '0;
    bus.iDP_rs1_nick     = '0;
    bus.iDP_rs2_nick     = '0;
    bus.iDP_rs1_dt       = '0;
    bus.iDP_rs2_dt       = '0;
    bus.iEX_en           = 1'b0;
    bus.iEX_nick         = '0;
    bus.iEX_dt           = '0;
    bus.iROB_commit_en   = 1'b0;
    bus.iROB_commit_nick = '0;
    bus.iMC_done         = 1'b0;
    bus.iMC_dt           = '0;
    test_reset();
    test_lw();
    test_ext();
    test_store();
    test_snoop();
    test_back_to_back();
    test_full();
    test_flush_load();
    test_flush_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
